// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared constants and helpers for the time-tag capture path
package tt_pkg;

    // Default width of one time tag (clock-counter value)
    localparam int TT_DATA_W = 32;

    // Address width for a buffer of the given depth (at least one bit)
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Increment that sticks at 2^w-1 instead of wrapping; w must be below 64
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] w_max;
        w_max = (64'd1 << w) - 64'd1;
        return (v >= w_max) ? w_max : v + 64'd1;
    endfunction

endpackage

// File: rtl/tt_tag_ram.sv
// rtl/tt_tag_ram.sv - DEPTHxDATA_W simple dual-port tag store with registered read
module tt_tag_ram
    import tt_pkg::*;
#(
    parameter int DATA_W = TT_DATA_W,
    parameter int DEPTH  = 8,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register; a write to the slot being read lands directly so a tag
    // entering an empty buffer (or becoming head as the last one leaves) is
    // presented after the same edge that stores it
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tt_tag_reader.sv
// rtl/tt_tag_reader.sv - time-tag capture buffer with valid/ready readout and overflow count
module tt_tag_reader
    import tt_pkg::*;
#(
    parameter int DATA_W = TT_DATA_W,
    parameter int DEPTH  = 8,
    parameter int OVF_W  = 16,
    localparam int AW    = ptr_w(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [DATA_W-1:0] regin,
    output logic [DATA_W-1:0] tag_out,
    output logic              tag_valid,
    input  logic              tag_ready,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic [OVF_W-1:0]  ovf_count,
    input  logic              ovf_clear
);

    // Write/read counts carry one extra bit so full and empty are distinct
    logic [LW-1:0]    r_wr_cnt;
    logic [LW-1:0]    r_rd_cnt;
    logic [OVF_W-1:0] r_ovf;

    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [LW-1:0] w_rd_cnt_nxt;
    logic          w_we;

    assign w_level = r_wr_cnt - r_rd_cnt;
    assign w_full  = (w_level == LW'(DEPTH));
    assign w_valid = (w_level != '0);

    // A pop in the same cycle frees a slot, so a full buffer still accepts ce
    assign w_pop  = w_valid && tag_ready;
    assign w_push = ce && (!w_full || w_pop);
    assign w_drop = ce && w_full && !w_pop;

    // Read address looks one step ahead so the head tag is already registered
    assign w_rd_cnt_nxt = r_rd_cnt + LW'(w_pop);
    assign w_we         = w_push && !reset;

    tt_tag_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt[AW-1:0]),
        .i_wdata (regin),
        .i_raddr (w_rd_cnt_nxt[AW-1:0]),
        .o_rdata (tag_out)
    );

    // Write and read counts advance on push and pop; reset empties the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_cnt <= r_wr_cnt + LW'(1);
            end
            r_rd_cnt <= w_rd_cnt_nxt;
        end
    end

    // Saturating drop counter; a clear coinciding with a drop leaves one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else if (ovf_clear) begin
            r_ovf <= w_drop ? OVF_W'(1) : '0;
        end else if (w_drop) begin
            r_ovf <= OVF_W'(sat_inc(64'(r_ovf), OVF_W));
        end
    end

    assign tag_valid = w_valid;
    assign level     = w_level;
    assign full      = w_full;
    assign ovf_count = r_ovf;

endmodule

// File: tb/tb_tt_tag_reader.sv
// tb/tb_tt_tag_reader.sv - directed self-checking bench for tt_tag_reader
module tb_tt_tag_reader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int OVF_W  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce;
    logic [DATA_W-1:0] regin;
    logic [DATA_W-1:0] tag_out;
    logic              tag_valid;
    logic              tag_ready;
    logic [LW-1:0]     level;
    logic              full;
    logic [OVF_W-1:0]  ovf_count;
    logic              ovf_clear;

    int n_cmp  = 0;
    int n_fail = 0;

    tt_tag_reader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OVF_W  (OVF_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .regin     (regin),
        .tag_out   (tag_out),
        .tag_valid (tag_valid),
        .tag_ready (tag_ready),
        .level     (level),
        .full      (full),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; regin = '0; tag_ready = 1'b0; ovf_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", 64'(tag_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ovf", 64'(ovf_count), 64'd0);

        // Single capture then single pop
        ce = 1'b1; regin = 32'h0000_1234;
        tick();
        ce = 1'b0; regin = 32'hDEAD_0000;
        check("one_valid", 64'(tag_valid), 64'd1);
        check("one_tag", 64'(tag_out), 64'h1234);
        check("one_level", 64'(level), 64'd1);
        tick();
        check("one_hold", 64'(tag_out), 64'h1234);
        tag_ready = 1'b1;
        tick();
        tag_ready = 1'b0;
        check("one_pop_valid", 64'(tag_valid), 64'd0);
        check("one_pop_level", 64'(level), 64'd0);

        // Fill past full: 0..7 stored, 8 and 9 dropped
        for (int i = 0; i < 10; i++) begin
            ce = 1'b1; regin = 32'(i);
            tick();
        end
        ce = 1'b0;
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_level", 64'(level), 64'd8);
        check("ovf_count2", 64'(ovf_count), 64'd2);
        tag_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_tag", 64'(tag_out), 64'(i));
            tick();
        end
        tag_ready = 1'b0;
        check("drain_empty", 64'(tag_valid), 64'd0);

        // Full buffer, push and pop together
        for (int i = 0; i < 8; i++) begin
            ce = 1'b1; regin = 32'h10 + 32'(i);
            tick();
        end
        ce = 1'b1; regin = 32'hAA; tag_ready = 1'b1;
        tick();
        ce = 1'b0;
        check("pp_level", 64'(level), 64'd8);
        check("pp_ovf", 64'(ovf_count), 64'd2);
        for (int i = 1; i < 8; i++) begin
            check("pp_tag", 64'(tag_out), 64'h10 + 64'(i));
            tick();
        end
        check("pp_last", 64'(tag_out), 64'hAA);
        tick();
        tag_ready = 1'b0;
        check("pp_empty", 64'(level), 64'd0);

        // Streaming: one in, one out every cycle
        for (int i = 0; i < 40; i++) begin
            ce = 1'b1; tag_ready = 1'b1; regin = 32'd100 + 32'(i);
            tick();
            check("st_tag", 64'(tag_out), 64'd100 + 64'(i));
            check("st_level", 64'(level), 64'd1);
        end
        ce = 1'b0;
        tick();
        tag_ready = 1'b0;
        check("st_empty", 64'(level), 64'd0);

        // Saturation and clear
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("clr_zero", 64'(ovf_count), 64'd0);
        for (int i = 0; i < 8; i++) begin
            ce = 1'b1; regin = 32'h200 + 32'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            regin = 32'h300 + 32'(i);
            tick();
        end
        check("sat_15", 64'(ovf_count), 64'd15);
        check("sat_head", 64'(tag_out), 64'h200);
        ovf_clear = 1'b1;
        tick();
        check("clr_drop", 64'(ovf_count), 64'd1);
        ce = 1'b0;
        tick();
        ovf_clear = 1'b0;
        check("clr_alone", 64'(ovf_count), 64'd0);

        // Reset mid-stream with level 5
        ce = 1'b1;
        tick();
        ce = 1'b0;
        check("pre_ovf", 64'(ovf_count), 64'd1);
        tag_ready = 1'b1;
        tick(); tick(); tick();
        tag_ready = 1'b0;
        check("pre_level", 64'(level), 64'd5);
        check("pre_head", 64'(tag_out), 64'h203);
        reset = 1'b1; tag_ready = 1'b1;
        tick();
        reset = 1'b0; tag_ready = 1'b0;
        check("mrst_valid", 64'(tag_valid), 64'd0);
        check("mrst_level", 64'(level), 64'd0);
        check("mrst_ovf", 64'(ovf_count), 64'd0);
        check("mrst_full", 64'(full), 64'd0);
        ce = 1'b1; regin = 32'hBEEF;
        tick();
        check("post_tag", 64'(tag_out), 64'hBEEF);
        check("post_level", 64'(level), 64'd1);
        regin = 32'hCAFE; tag_ready = 1'b1;
        tick();
        ce = 1'b0;
        check("post_pp_tag", 64'(tag_out), 64'hCAFE);
        check("post_pp_level", 64'(level), 64'd1);
        tick();
        tag_ready = 1'b0;
        check("post_empty", 64'(tag_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
